// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID fetch queue.
// The packet layout below matches the default 32-bit datapath.
package if_id_pkg;

    localparam int PKT_XLEN = 32;

    typedef struct packed {
        logic [PKT_XLEN-1:0] pc;
        logic [PKT_XLEN-1:0] instr;
    } fetch_pkt_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    // Low PC bits that must be zero for an instruction-aligned target.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/if_id_fifo.sv
// Small FIFO of fetch packets with a registered head and a synchronous clear.
// The head register holds its last value when the FIFO drains or is cleared.
module if_id_fifo
    import if_id_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_pkt_t,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] remain;

    always_comb begin
        rd_next = rd_ptr + AW'(pop);
        remain  = count - CW'(pop);
    end

    // Head is refreshed to whatever will sit at the read pointer after this edge,
    // bypassing the storage when a push lands in an otherwise empty FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (clear) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= remain + CW'(push);
            if (remain != '0) begin
                head <= mem[rd_next];
            end else if (push) begin
                head <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID receiver: buffers fetched {pc, instr} pairs for decode and drives the fetch redirect.
// Defining IF_ID_PERF_EN adds the perf_redirects/perf_squashed counters.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int XLEN     = 32,
    parameter int SQUASH_N = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            in_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_ready,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_pc,
    output logic            misalign
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_squashed
`endif
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam int            SW      = (SQUASH_N > 1) ? $clog2(SQUASH_N) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] SQ_LOAD = SW'(SQUASH_N - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } pkt_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] sq_cnt;
    logic [SW-1:0] sq_cnt_next;
    logic [CW-1:0] count;
    logic          dropping;
    logic          push;
    logic          pop;
    pkt_t          push_data;
    pkt_t          head;

    assign in_ready  = count < DEPTH_C;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;

    // The last SQUASH cycle (sq_cnt==0) already accepts the target fetch.
    assign dropping  = (state == ST_SQUASH) && (sq_cnt != '0);
    assign push      = in_valid && in_ready && !dropping && !ex_redirect;
    assign push_data = '{pc: in_pc, instr: in_instr};

    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    if_id_fifo #(
        .DEPTH (DEPTH),
        .T     (pkt_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (ex_redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_next  = state;
        sq_cnt_next = sq_cnt;
        if (ex_redirect) begin
            state_next  = ST_SQUASH;
            sq_cnt_next = SQ_LOAD;
        end else if (state == ST_SQUASH) begin
            if (sq_cnt == '0) begin
                state_next = ST_RUN;
            end else begin
                sq_cnt_next = sq_cnt - SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            sq_cnt       <= '0;
            branch_taken <= 1'b0;
            branch_pc    <= '0;
            misalign     <= 1'b0;
        end else begin
            state        <= state_next;
            sq_cnt       <= sq_cnt_next;
            branch_taken <= ex_redirect;
            if (ex_redirect) begin
                branch_pc <= ex_target & ~{{(XLEN-2){1'b0}}, ALIGN_MASK};
                misalign  <= |(ex_target[1:0] & ALIGN_MASK);
            end
        end
    end

`ifdef IF_ID_PERF_EN
    logic [CW-1:0] flushed;
    logic          beat_dropped;

    // Entries still queued after this edge's pop are lost, as is any fetch beat refused by the squash.
    assign flushed      = ex_redirect ? (count - CW'(pop)) : '0;
    assign beat_dropped = in_valid && in_ready && (ex_redirect || dropping);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_redirects <= '0;
            perf_squashed  <= '0;
        end else begin
            if (ex_redirect) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            perf_squashed <= perf_squashed + 32'(flushed) + 32'(beat_dropped);
        end
    end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios then random traffic against a queue-based model.
// Build with IF_ID_PERF_EN to also hook up the perf counter ports.
module tb_if_id_queue;
    import if_id_pkg::*;

    localparam int DEPTH    = 2;
    localparam int XLEN     = 32;
    localparam int SQUASH_N = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_ready;
    logic            ex_redirect;
    logic [XLEN-1:0] ex_target;
    logic            branch_taken;
    logic [XLEN-1:0] branch_pc;
    logic            misalign;
`ifdef IF_ID_PERF_EN
    logic [31:0]     perf_redirects;
    logic [31:0]     perf_squashed;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: queue contents, remaining wrong-path beats to drop, redirect outputs.
    fetch_pkt_t m_q[$];
    fetch_pkt_t exp_q[$];
    fetch_pkt_t m_last;
    int         m_drop;
    logic       m_bt;
    logic [31:0] m_bpc;
    logic       m_mis;

    always #5 clk = ~clk;

    if_id_queue #(
        .DEPTH    (DEPTH),
        .XLEN     (XLEN),
        .SQUASH_N (SQUASH_N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_ready    (out_ready),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .misalign     (misalign)
`ifdef IF_ID_PERF_EN
        ,
        .perf_redirects (perf_redirects),
        .perf_squashed  (perf_squashed)
`endif
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        exp_q.delete();
        m_last = '0;
        m_drop = 0;
        m_bt   = 1'b0;
        m_bpc  = '0;
        m_mis  = 1'b0;
    endtask

    task automatic checkOutput();
        fetch_pkt_t h;
        h = (m_q.size() > 0) ? m_q[0] : m_last;
        checkVal("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
        checkVal("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        checkVal("out_pc", out_pc, h.pc);
        checkVal("out_instr", out_instr, h.instr);
        checkVal("branch_taken", 32'(branch_taken), 32'(m_bt));
        checkVal("branch_pc", branch_pc, m_bpc);
        checkVal("misalign", 32'(misalign), 32'(m_mis));
    endtask

    // One clock cycle: drive inputs, log expected pops, check at negedge, then advance the model.
    task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic ordy, input logic redir, input logic [31:0] tgt);
        logic pop;
        logic acc;
        @(posedge clk);
        #2;
        in_valid    = iv;
        in_pc       = pc;
        in_instr    = instr;
        out_ready   = ordy;
        ex_redirect = redir;
        ex_target   = tgt;
        pop = (m_q.size() > 0) && ordy;
        acc = iv && (m_q.size() < DEPTH) && !redir && (m_drop == 0);
        if (pop) exp_q.push_back(m_q[0]);
        @(negedge clk);
        checkOutput();
        if (pop) void'(m_q.pop_front());
        m_bt = redir;
        if (redir) begin
            m_q.delete();
            m_drop = SQUASH_N - 1;
            m_bpc  = {tgt[31:2], 2'b00};
            m_mis  = (tgt[1:0] != 2'b00);
        end else if (m_drop > 0) begin
            m_drop--;
        end else if (acc) begin
            m_q.push_back('{pc: pc, instr: instr});
        end
        if (m_q.size() > 0) m_last = m_q[0];
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 32'h0, 32'h0, ordy, 1'b0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic ordy);
        applyStimulus(1'b1, pc, pc ^ 32'h1357_9bdf, ordy, 1'b0, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic iv, input logic [31:0] pc);
        applyStimulus(iv, pc, pc ^ 32'h1357_9bdf, 1'b0, 1'b1, tgt);
    endtask

    // Asserts reset mid-cycle and checks that outputs clear before any clock edge.
    task automatic asyncReset(input string tag);
        #1;
        reset = 1'b1;
        #1;
        checkVal({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkVal({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        checkVal({tag, "_branch_taken"}, 32'(branch_taken), 32'd0);
        checkVal({tag, "_branch_pc"}, branch_pc, 32'd0);
        checkVal({tag, "_misalign"}, 32'(misalign), 32'd0);
        checkVal({tag, "_out_pc"}, out_pc, 32'd0);
`ifdef IF_ID_PERF_EN
        checkVal({tag, "_perf_redirects"}, perf_redirects, 32'd0);
        checkVal({tag, "_perf_squashed"}, perf_squashed, 32'd0);
`endif
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        ex_redirect = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        modelReset();
    endtask

    // Monitor: every decode handshake must match the next entry the model released.
    always @(negedge clk) begin
        fetch_pkt_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_pop: got pc %h expected no handshake", out_pc);
            end else begin
                e = exp_q.pop_front();
                checkVal("pop_pc", out_pc, e.pc);
                checkVal("pop_instr", out_instr, e.instr);
            end
        end
    end

    initial begin
        logic        r_iv;
        logic        r_ordy;
        logic        r_redir;
        logic [31:0] r_pc;
        logic [31:0] r_instr;
        logic [31:0] r_tgt;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_pc       = '0;
        in_instr    = '0;
        out_ready   = 1'b0;
        ex_redirect = 1'b0;
        ex_target   = '0;
        modelReset();
        #3;
        checkVal("por_out_valid", 32'(out_valid), 32'd0);
        checkVal("por_in_ready", 32'(in_ready), 32'd1);
        checkVal("por_branch_taken", 32'(branch_taken), 32'd0);
        checkVal("por_branch_pc", branch_pc, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        $display("[TB] idle after reset");
        repeat (10) idle(1'b0);

        $display("[TB] fill to full, then drain in order");
        fetch(32'h0, 1'b0);
        fetch(32'h4, 1'b0);
        fetch(32'h8, 1'b0);
        checkVal("full_in_ready", 32'(in_ready), 32'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        checkVal("drained_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] redirect flushes queue and drops one wrong-path fetch");
        fetch(32'h0, 1'b0);
        fetch(32'h4, 1'b0);
        redirect(32'h40, 1'b1, 32'h8);
        fetch(32'hC, 1'b0);
        checkVal("redir_branch_taken", 32'(branch_taken), 32'd1);
        checkVal("redir_branch_pc", branch_pc, 32'h40);
        checkVal("redir_out_valid", 32'(out_valid), 32'd0);
        fetch(32'h40, 1'b0);
        idle(1'b1);
        checkVal("target_out_pc", out_pc, 32'h40);
        idle(1'b0);

        $display("[TB] back-to-back redirects");
        redirect(32'h100, 1'b1, 32'h50);
        redirect(32'h200, 1'b1, 32'h100);
        checkVal("b2b_first_pc", branch_pc, 32'h100);
        fetch(32'h104, 1'b0);
        checkVal("b2b_second_pc", branch_pc, 32'h200);
        checkVal("b2b_second_taken", 32'(branch_taken), 32'd1);
        fetch(32'h200, 1'b0);
        idle(1'b1);
        checkVal("b2b_head_pc", out_pc, 32'h200);
        idle(1'b0);

        $display("[TB] misaligned target");
        redirect(32'h43, 1'b0, 32'h0);
        idle(1'b0);
        checkVal("mis_branch_pc", branch_pc, 32'h40);
        checkVal("mis_set", 32'(misalign), 32'd1);
        idle(1'b0);
        checkVal("mis_hold", 32'(misalign), 32'd1);
        redirect(32'h80, 1'b0, 32'h0);
        idle(1'b0);
        checkVal("mis_clear", 32'(misalign), 32'd0);

        $display("[TB] asynchronous reset with a full queue and during squash");
        fetch(32'h10, 1'b0);
        fetch(32'h14, 1'b0);
        idle(1'b0);
        asyncReset("rst_full");
        fetch(32'h20, 1'b0);
        fetch(32'h24, 1'b0);
        redirect(32'h43, 1'b1, 32'h28);
        idle(1'b0);
        asyncReset("rst_squash");
        idle(1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            r_iv    = ($urandom_range(0, 99) < 70);
            r_ordy  = ($urandom_range(0, 99) < 60);
            r_redir = ($urandom_range(0, 99) < 10);
            r_pc    = $urandom;
            r_instr = $urandom;
            r_tgt   = $urandom;
            applyStimulus(r_iv, r_pc, r_instr, r_ordy, r_redir, r_tgt);
        end
        repeat (DEPTH + 2) idle(1'b1);
        checkVal("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
